// File: rtl/sik_fetch_if.sv
// Fetch-stage bus: instruction-memory port, decode-facing output register,
// and the redirect/halt/stall controls coming back from downstream.
interface sik_fetch_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic        redirect_tid;
    logic [15:0] redirect_pc;
    logic        halt_req;
    logic        halt_tid;
    logic        out_valid;
    logic        out_tid;
    logic [15:0] out_pc;
    logic [15:0] out_inst;
    logic        out_has_pre;
    logic [3:0]  out_pre;
    logic [1:0]  halted;
    logic        all_halted;

    modport master (
        output imem_addr, out_valid, out_tid, out_pc, out_inst, out_has_pre, out_pre,
               halted, all_halted,
        input  imem_data, stall, redirect_valid, redirect_tid, redirect_pc,
               halt_req, halt_tid
    );

    modport slave (
        input  imem_addr, out_valid, out_tid, out_pc, out_inst, out_has_pre, out_pre,
               halted, all_halted,
        output imem_data, stall, redirect_valid, redirect_tid, redirect_pc,
               halt_req, halt_tid
    );
endinterface

// File: rtl/sik_fetch.sv
// Dual-thread round-robin instruction fetch for the SIK stack processor;
// folds pre words into a per-thread prefix register and honours redirect/halt.
module sik_fetch #(
    parameter logic [15:0] PC0_INIT = 16'h0000,
    parameter logic [15:0] PC1_INIT = 16'h8000
) (
    input  logic            clk,
    input  logic            reset,
    sik_fetch_if.master     bus
);

    logic [1:0][15:0] pc_q, pc_d;
    logic [1:0][3:0]  pre_val_q, pre_val_d;
    logic [1:0]       pre_ok_q, pre_ok_d;
    logic [1:0]       halted_q, halted_d;
    logic             all_halted_q, all_halted_d;
    logic             last_tid_q, last_tid_d;
    logic             out_valid_q, out_valid_d;
    logic             out_tid_q, out_tid_d;
    logic [15:0]      out_pc_q, out_pc_d;
    logic [15:0]      out_inst_q, out_inst_d;
    logic             out_has_pre_q, out_has_pre_d;
    logic [3:0]       out_pre_q, out_pre_d;

    logic             sel_s;
    logic             can_fetch_s;
    logic             fetch_s;
    logic             kill_s;
    logic             is_pre_s;
    logic [1:0]       rd_hit_s;
    logic [1:0]       hd_hit_s;

    // Thread selection: prefer the other thread, fall back to the same one.
    always_comb begin
        if (!halted_q[~last_tid_q]) begin
            sel_s       = ~last_tid_q;
            can_fetch_s = 1'b1;
        end else if (!halted_q[last_tid_q]) begin
            sel_s       = last_tid_q;
            can_fetch_s = 1'b1;
        end else begin
            sel_s       = last_tid_q;
            can_fetch_s = 1'b0;
        end
    end

    assign bus.imem_addr = pc_q[sel_s];
    assign fetch_s       = can_fetch_s & ~bus.stall;
    assign rd_hit_s      = {bus.redirect_valid & bus.redirect_tid, bus.redirect_valid & ~bus.redirect_tid};
    assign hd_hit_s      = {bus.halt_req & bus.halt_tid, bus.halt_req & ~bus.halt_tid};
    assign kill_s        = rd_hit_s[sel_s] | hd_hit_s[sel_s];
    assign is_pre_s      = (bus.imem_data[15:12] == 4'hF);

    // Next-state: fetch/prefix fold, then redirect and halt overrides.
    always_comb begin
        pc_d          = pc_q;
        pre_val_d     = pre_val_q;
        pre_ok_d      = pre_ok_q;
        last_tid_d    = last_tid_q;
        out_valid_d   = out_valid_q;
        out_tid_d     = out_tid_q;
        out_pc_d      = out_pc_q;
        out_inst_d    = out_inst_q;
        out_has_pre_d = out_has_pre_q;
        out_pre_d     = out_pre_q;

        if (fetch_s) begin
            last_tid_d    = sel_s;
            pc_d[sel_s]   = pc_q[sel_s] + 16'd1;
            if (!kill_s && is_pre_s) begin
                pre_val_d[sel_s] = bus.imem_data[3:0];
                pre_ok_d[sel_s]  = 1'b1;
                out_valid_d      = 1'b0;
            end else if (!kill_s) begin
                out_valid_d     = 1'b1;
                out_tid_d       = sel_s;
                out_pc_d        = pc_q[sel_s];
                out_inst_d      = bus.imem_data;
                out_has_pre_d   = pre_ok_q[sel_s];
                out_pre_d       = pre_val_q[sel_s];
                pre_ok_d[sel_s] = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!bus.stall) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        // The held instruction is stale once its own thread is redirected or halted.
        out_valid_d = out_valid_d & ~(rd_hit_s[out_tid_d] | hd_hit_s[out_tid_d]);
        for (int t = 0; t < 2; t++) begin
            pc_d[t]     = rd_hit_s[t] ? bus.redirect_pc : pc_d[t];
            pre_ok_d[t] = pre_ok_d[t] & ~rd_hit_s[t];
            halted_d[t] = halted_q[t] | hd_hit_s[t];
        end
        all_halted_d = &halted_d;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= {PC1_INIT, PC0_INIT};
            pre_val_q     <= 8'h00;
            pre_ok_q      <= 2'b00;
            halted_q      <= 2'b00;
            all_halted_q  <= 1'b0;
            last_tid_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_tid_q     <= 1'b0;
            out_pc_q      <= 16'h0000;
            out_inst_q    <= 16'h0000;
            out_has_pre_q <= 1'b0;
            out_pre_q     <= 4'h0;
        end else begin
            pc_q          <= pc_d;
            pre_val_q     <= pre_val_d;
            pre_ok_q      <= pre_ok_d;
            halted_q      <= halted_d;
            all_halted_q  <= all_halted_d;
            last_tid_q    <= last_tid_d;
            out_valid_q   <= out_valid_d;
            out_tid_q     <= out_tid_d;
            out_pc_q      <= out_pc_d;
            out_inst_q    <= out_inst_d;
            out_has_pre_q <= out_has_pre_d;
            out_pre_q     <= out_pre_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_tid     = out_tid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_inst    = out_inst_q;
    assign bus.out_has_pre = out_has_pre_q;
    assign bus.out_pre     = out_pre_q;
    assign bus.halted      = halted_q;
    assign bus.all_halted  = all_halted_q;

endmodule

// File: tb/tb_sik_fetch.sv
// Scoreboard bench for sik_fetch: directed scenarios push expected outputs,
// a negedge monitor pops and compares whatever decode consumes.
module tb_sik_fetch;

    typedef struct packed {
        logic        tid;
        logic [15:0] pc;
        logic [15:0] inst;
        logic        has_pre;
        logic [3:0]  pre;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] mem [0:65535];
    exp_t        exp_q [$];
    int          n_cmp;
    int          n_err;

    sik_fetch_if bus ();

    sik_fetch #(.PC0_INIT(16'h0000), .PC1_INIT(16'h8000)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end (got timeout, required finish)");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic push(input logic tid, input logic [15:0] pc, input logic [15:0] inst,
                        input logic hp, input logic [3:0] pre);
        exp_t e;
        e.tid = tid; e.pc = pc; e.inst = inst; e.has_pre = hp; e.pre = pre;
        exp_q.push_back(e);
    endtask

    task automatic init_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h3000 | (i[15:0] & 16'h0FFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_tid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt_req = 1'b0;
        bus.halt_tid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic finish_scn();
        @(negedge clk);
        #1;
    endtask

    // Decode consumes the held instruction whenever it is valid and not stalled.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && !bus.stall) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_extra: got tid=%0d pc=%h inst=%h, required no output",
                         bus.out_tid, bus.out_pc, bus.out_inst);
            end else begin
                exp_t e;
                exp_t g;
                e = exp_q.pop_front();
                g.tid = bus.out_tid; g.pc = bus.out_pc; g.inst = bus.out_inst;
                g.has_pre = bus.out_has_pre; g.pre = bus.out_pre;
                n_cmp++;
                if (g !== e) begin
                    n_err++;
                    $display("FAIL out_word: got tid=%0d pc=%h inst=%h hp=%0d pre=%h, required tid=%0d pc=%h inst=%h hp=%0d pre=%h",
                             g.tid, g.pc, g.inst, g.has_pre, g.pre, e.tid, e.pc, e.inst, e.has_pre, e.pre);
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_tid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt_req = 1'b0;
        bus.halt_tid = 1'b0;
        init_mem();
        #1 rst = 1'b1;
        #1;
        chk("rst_valid", {39'd0, bus.out_valid}, 40'd0);
        chk("rst_imem_addr", {24'd0, bus.imem_addr}, 40'h0000);
        chk("rst_halted", {37'd0, bus.all_halted, bus.halted}, 40'd0);

        // Basic interleave.
        init_mem();
        mem[16'h0000] = 16'h1001; mem[16'h8000] = 16'h8005; mem[16'h0001] = 16'h2002;
        do_reset();
        push(1'b0, 16'h0000, 16'h1001, 1'b0, 4'h0);
        push(1'b1, 16'h8000, 16'h8005, 1'b0, 4'h0);
        push(1'b0, 16'h0001, 16'h2002, 1'b0, 4'h0);
        repeat (3) step();
        finish_scn();

        // Prefix folding, including an overwritten prefix.
        init_mem();
        mem[16'h0000] = 16'hF00A; mem[16'h0001] = 16'h4123;
        mem[16'h0002] = 16'hF003; mem[16'h0003] = 16'hF007; mem[16'h0004] = 16'h5555;
        do_reset();
        push(1'b1, 16'h8000, 16'h3000, 1'b0, 4'h0);
        push(1'b0, 16'h0001, 16'h4123, 1'b1, 4'hA);
        push(1'b1, 16'h8001, 16'h3001, 1'b0, 4'h0);
        push(1'b1, 16'h8002, 16'h3002, 1'b0, 4'h0);
        push(1'b1, 16'h8003, 16'h3003, 1'b0, 4'h0);
        push(1'b0, 16'h0004, 16'h5555, 1'b1, 4'h7);
        push(1'b1, 16'h8004, 16'h3004, 1'b0, 4'h0);
        push(1'b0, 16'h0005, 16'h3005, 1'b0, 4'h7);
        step();
        chk("pre_bubble", {39'd0, bus.out_valid}, 40'd0);
        repeat (4) step();
        chk("pre_bubble2", {39'd0, bus.out_valid}, 40'd0);
        repeat (6) step();
        finish_scn();

        // Stall holds output and PCs.
        init_mem();
        do_reset();
        push(1'b0, 16'h0000, 16'h3000, 1'b0, 4'h0);
        push(1'b1, 16'h8000, 16'h3000, 1'b0, 4'h0);
        push(1'b0, 16'h0001, 16'h3001, 1'b0, 4'h0);
        push(1'b1, 16'h8001, 16'h3001, 1'b0, 4'h0);
        push(1'b0, 16'h0002, 16'h3002, 1'b0, 4'h0);
        push(1'b1, 16'h8002, 16'h3002, 1'b0, 4'h0);
        repeat (4) step();
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_out", {6'd0, bus.out_valid, bus.out_tid, bus.out_pc, bus.out_inst},
                {6'd0, 1'b1, 1'b1, 16'h8001, 16'h3001});
            chk("stall_addr", {24'd0, bus.imem_addr}, 40'h0002);
        end
        bus.stall = 1'b0;
        repeat (2) step();
        finish_scn();

        // Redirect of held thread under stall, then redirect of selected thread.
        init_mem();
        do_reset();
        push(1'b1, 16'h8000, 16'h3000, 1'b0, 4'h0);
        push(1'b0, 16'h0040, 16'h3040, 1'b0, 4'h0);
        push(1'b1, 16'h8001, 16'h3001, 1'b0, 4'h0);
        push(1'b1, 16'h8002, 16'h3002, 1'b0, 4'h0);
        push(1'b0, 16'h0100, 16'h3100, 1'b0, 4'h0);
        step();
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1; bus.redirect_tid = 1'b0; bus.redirect_pc = 16'h0040;
        step();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        chk("redir_kill", {39'd0, bus.out_valid}, 40'd0);
        chk("redir_addr", {24'd0, bus.imem_addr}, 40'h8000);
        repeat (3) step();
        bus.redirect_valid = 1'b1; bus.redirect_tid = 1'b0; bus.redirect_pc = 16'h0100;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_same", {39'd0, bus.out_valid}, 40'd0);
        chk("redir_same_addr", {24'd0, bus.imem_addr}, 40'h8002);
        repeat (2) step();
        finish_scn();

        // Halt thread 1, then thread 0.
        init_mem();
        do_reset();
        push(1'b0, 16'h0000, 16'h3000, 1'b0, 4'h0);
        push(1'b0, 16'h0001, 16'h3001, 1'b0, 4'h0);
        push(1'b0, 16'h0002, 16'h3002, 1'b0, 4'h0);
        push(1'b0, 16'h0003, 16'h3003, 1'b0, 4'h0);
        bus.halt_req = 1'b1; bus.halt_tid = 1'b1;
        step();
        bus.halt_req = 1'b0;
        chk("halt1", {37'd0, bus.all_halted, bus.halted}, {37'd0, 1'b0, 2'b10});
        repeat (3) step();
        bus.halt_req = 1'b1; bus.halt_tid = 1'b0;
        step();
        bus.halt_req = 1'b0;
        chk("halt_all", {37'd0, bus.all_halted, bus.halted}, {37'd0, 1'b1, 2'b11});
        chk("halt_kill", {39'd0, bus.out_valid}, 40'd0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("halt_frozen", {23'd0, bus.out_valid, bus.imem_addr}, {23'd0, 1'b0, 16'h0005});
        end
        finish_scn();

        // PC wrap, then asynchronous reset mid-stream.
        init_mem();
        do_reset();
        push(1'b1, 16'h8000, 16'h3000, 1'b0, 4'h0);
        push(1'b0, 16'hFFFF, 16'h3FFF, 1'b0, 4'h0);
        push(1'b1, 16'h8001, 16'h3001, 1'b0, 4'h0);
        bus.redirect_valid = 1'b1; bus.redirect_tid = 1'b0; bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect_valid = 1'b0;
        chk("wrap_setup", {23'd0, bus.out_valid, bus.imem_addr}, {23'd0, 1'b0, 16'h8000});
        repeat (3) step();
        chk("wrap_addr", {24'd0, bus.imem_addr}, 40'h0000);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_out", {2'd0, bus.out_valid, bus.out_tid, bus.out_pc, bus.out_inst, bus.out_has_pre, bus.out_pre},
            40'd0);
        chk("arst_state", {21'd0, bus.all_halted, bus.halted, bus.imem_addr}, 40'd0);

        chk("queue_drained", exp_q.size(), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
